// File: rtl/vmem_port_arbiter_if.sv
// vmem_port_arbiter_if: requester ports, clear control and memory port-A bundle for the display-memory arbiter
interface vmem_port_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          mem_ena;
    logic          mem_wea;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina;
    logic [DW-1:0] mem_douta;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_ena, mem_wea, mem_addra, mem_dina,
        input  mem_douta
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_ena, mem_wea, mem_addra, mem_dina,
        output mem_douta
    );
endinterface

// File: rtl/vmem_port_arbiter.sv
// vmem_port_arbiter: round-robin two-port arbiter with clear sequencer on display memory port A
module vmem_port_arbiter #(
    parameter int AW = 3,
    parameter int DW = 32,
    parameter int RD_LAT = 1,
    parameter logic [DW-1:0] FILL = DW'(32'h30)
) (
    input logic clk,
    input logic rst,
    vmem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, RWAIT, RESP, CLEAR} state_t;
    state_t state, nxt;
    logic clr_pend, last_grant, win, l_we, g_id, last_rd, last_clr, clr_done_q;
    logic [AW-1:0] l_addr, cnt;
    logic [DW-1:0] l_wdata, p0_rdata_q, p1_rdata_q;
    logic [2:0] wcnt;

    // port 1 wins when alone or when port 0 was the last one served
    assign g_id = !(bus.p0_req && (!bus.p1_req || last_grant));
    assign last_rd = wcnt == 3'(RD_LAT - 1);
    assign last_clr = cnt == {AW{1'b1}};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (clr_pend || bus.clr_start) ? CLEAR : (bus.p0_req || bus.p1_req) ? ACCESS : IDLE;
            ACCESS:  nxt = l_we ? RESP : RWAIT;
            RWAIT:   nxt = last_rd ? RESP : RWAIT;
            RESP:    nxt = IDLE;
            CLEAR:   nxt = last_clr ? IDLE : CLEAR;
            default: nxt = IDLE;
        endcase
        bus.mem_ena = state == ACCESS || state == CLEAR;
        bus.mem_wea = state == CLEAR || (state == ACCESS && l_we);
        bus.mem_addra = state == CLEAR ? cnt : state == ACCESS ? l_addr : '0;
        bus.mem_dina = state == CLEAR ? FILL : state == ACCESS ? l_wdata : '0;
        bus.p0_ack = state == RESP && !win;
        bus.p1_ack = state == RESP && win;
        bus.clr_busy = state == CLEAR;
        bus.clr_done = clr_done_q;
        bus.p0_rdata = p0_rdata_q;
        bus.p1_rdata = p1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            clr_pend <= 1'b0;
            last_grant <= 1'b1;
            win <= 1'b0;
            l_we <= 1'b0;
            l_addr <= '0;
            l_wdata <= '0;
            cnt <= '0;
            wcnt <= '0;
            clr_done_q <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state <= nxt;
            clr_pend <= (state == CLEAR || nxt == CLEAR) ? 1'b0 : clr_pend || bus.clr_start;
            clr_done_q <= state == CLEAR && last_clr;
            cnt <= state == CLEAR ? cnt + 1'b1 : '0;
            wcnt <= state == RWAIT ? wcnt + 1'b1 : '0;
            if (state == IDLE && nxt == ACCESS) begin
                win <= g_id;
                last_grant <= g_id;
                l_we <= g_id ? bus.p1_we : bus.p0_we;
                l_addr <= g_id ? bus.p1_addr : bus.p0_addr;
                l_wdata <= g_id ? bus.p1_wdata : bus.p0_wdata;
            end
            if (state == RWAIT && last_rd && !win) p0_rdata_q <= bus.mem_douta;
            if (state == RWAIT && last_rd && win) p1_rdata_q <= bus.mem_douta;
        end
    end
endmodule

// File: doc/vmem_port_arbiter.md
Name: vmem_port_arbiter

Overview:
- Owns port A of the 8-word x 32-bit display memory, the ASCII text buffer scanned out to the 8-digit display.
- Shares that port between two requesters: port 0 (CPU load/store path) and port 1 (debug console writer).
- Adds a built-in clear sequencer that fills every word with a fill character.
- Serialises all accesses with a req/ack handshake and round-robin fairness; the memory port sees at most one access at a time.

Parameters:
AW, 3, memory address width (DEPTH = 2**AW words)
DW, 32, data width
RD_LAT, 1, memory port-A read latency in cycles (1..4)
FILL, 32'h30, word written by clear sequence (ASCII '0')

Ports:
clk  in  1  system clock, same clock as memory port A
rst  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request; hold high with fields stable until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  AW  port 0 word address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  DW  port 0 read data, valid with p0_ack, held until next port-0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
clr_start  in  1  request clear of whole memory (pulse or level)
clr_busy  out  1  high from clear acceptance through last clear write
clr_done  out  1  one-cycle pulse after last clear write
mem_ena  out  1  memory port-A enable
mem_wea  out  1  memory port-A write enable
mem_addra  out  AW  memory address
mem_dina  out  DW  memory write data
mem_douta  in  DW  memory read data, RD_LAT cycles after mem_ena

Behaviour:
- Reset: all outputs 0. State IDLE, clr_pend = 0, last_grant = 1 (port 0 wins the first tie). Reset mid-transaction aborts it: no ack, no further mem_ena.
- FSM states: IDLE, ACCESS, RWAIT, RESP, CLEAR.
- clr_pend: set by clr_start in any state except CLEAR; cleared when CLEAR is entered.
- IDLE arbitration, priority order:
  - clr_pend or clr_start: go to CLEAR, clr_busy <= 1, address counter <= 0.
  - Only one port requesting: grant it.
  - Both ports requesting: grant the port != last_grant.
- On grant: latch winner id, we, addr and wdata; last_grant <= winner; go to ACCESS.
- ACCESS (exactly 1 cycle): mem_ena = 1, mem_wea = latched we, mem_addra/mem_dina = latched values. Next state: write goes to RESP, read goes to RWAIT.
- RWAIT: lasts RD_LAT cycles, with mem_ena = 0. On its final cycle, winner's rdata <= mem_douta. Next state RESP.
- RESP (1 cycle): winner's ack = 1; next state IDLE. The loser keeps req high and is granted on the next IDLE cycle.
- Latency from req seen in IDLE at cycle N:
  - Write: mem_ena at N+1, ack at N+2.
  - Read: mem_ena at N+1, ack at N+2+RD_LAT.
- Back-to-back: a port may keep req high after ack to issue a new access. It re-enters arbitration in IDLE and loses a tie to the other port.
- Request withdrawal: req dropped after grant does not cancel the access; ack still pulses. req dropped before grant is ignored.
- Request fields changing after grant have no effect, since values are latched.
- CLEAR sequencing:
  - One write per cycle: mem_ena = mem_wea = 1, mem_addra = counter, mem_dina = FILL.
  - Counter increments 0..DEPTH-1 with no wrap.
  - After the DEPTH-1 write: clr_busy <= 0, clr_done pulse next cycle, return to IDLE.
  - Port requests wait during CLEAR; they are not dropped.
- clr_start during ACCESS/RWAIT/RESP: the current access completes normally, then CLEAR runs before any waiting port.
- clr_start during CLEAR: ignored, no second pass.
- rdata of the non-winning port is never modified.

Test Plan:
- Single write then read: p0 writes addr 5 <= 32'h41; p0 reads addr 5. Required: write ack 2 cycles after req; read ack at 3 cycles with p0_rdata = 32'h41; exactly one mem_ena cycle per access.
- Simultaneous requests: p0 and p1 both write (addr 1 <= 'A', addr 2 <= 'B') from the cycle after reset. Required: p0 served first, then p1; acks 3 cycles apart; p0 rerequests and loses to pending p1.
- Sustained contention: both ports hold req for 20 accesses each. Required: grants strictly alternate and no port waits more than one access.
- Clear: clr_start pulse while p1 read is in RWAIT. Required: p1 read completes with correct data; then 8 writes of 32'h30 to addrs 0..7 on consecutive cycles; clr_done pulses once; memory readback is all 32'h30.
- Withdrawal: p0 drops req the cycle after grant. Required: access still performed and p0_ack pulses once; p0 req dropped before grant produces no mem_ena.
- Reset mid-operation: assert rst during CLEAR at counter 3. Required: next cycle all outputs 0, no clr_done, words 4..7 unchanged.
